if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 174 +++++++++++++++++
 tb/tb_if_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: keeps the fetch PC, issues one instruction-memory
// request at a time, and fills the IF/ID pipeline register. A one-entry skid
// buffer catches a response that arrives while decode is stalled. A redirect
// that lands while a response is still in flight makes the stage drain and
// discard that stale response before it fetches from the new target.
//
// Memory handshake: imem_req is a level request. While it is high, imem_addr
// names the word wanted and stays constant. The memory answers that request
// with exactly one imem_rvalid pulse carrying imem_rdata. The pulse may come
// in the same cycle the request first appears or any later cycle. The request
// is complete in the cycle imem_rvalid is high, so at most one request is
// ever outstanding.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        BranchTakenE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic [24:0] ImmD,
  output logic        ValidD,
  output logic [1:0]  dbg_state
);

  // FETCH: request active. HOLD: skid buffer full, waiting for decode.
  // DRAIN: redirected, waiting to discard the response still in flight.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_n;
  logic [31:0] pcf_q, pcf_n;
  logic [31:0] skid_q, skid_n;
  logic [31:0] instr_q, instr_n;
  logic [31:0] pcd_q, pcd_n;
  logic [31:0] pcp4_q, pcp4_n;
  logic        valid_q, valid_n;

  logic [31:0] target;
  logic [31:0] pcf_plus4;
  logic        kill_d;
  logic        unused_tgt_bits;

  // Redirect targets are forced word-aligned, so PCF[1:0] is always zero.
  assign target          = {PCTargetE[31:2], 2'b00};
  assign unused_tgt_bits = ^PCTargetE[1:0];
  // Arithmetic wraps modulo 2^32.
  assign pcf_plus4       = pcf_q + 32'd4;
  // Flush or redirect squashes whatever would sit in IF/ID after this edge.
  assign kill_d          = FlushD | BranchTakenE;

  // Request only while fetching, and never while reset is held.
  assign imem_req  = rst_ni & (state_q == FETCH);
  assign imem_addr = pcf_q;

  assign InstrD    = instr_q;
  assign PCD       = pcd_q;
  assign PCPlus4D  = pcp4_q;
  assign ImmD      = instr_q[31:7];
  assign ValidD    = valid_q;
  assign dbg_state = state_q;

  // Next-state, next-PC, skid buffer and IF/ID next values.
  always_comb begin
    state_n = state_q;
    pcf_n   = pcf_q;
    skid_n  = skid_q;
    instr_n = instr_q;
    pcd_n   = pcd_q;
    pcp4_n  = pcp4_q;
    valid_n = valid_q;

    case (state_q)
      FETCH: begin
        if (BranchTakenE) begin
          // A response in this cycle is simply dropped. Without one, the
          // in-flight response must be drained first.
          pcf_n   = target;
          state_n = imem_rvalid ? FETCH : DRAIN;
        end else if (imem_rvalid) begin
          if (StallD) begin
            skid_n  = imem_rdata;
            state_n = HOLD;
          end else begin
            instr_n = imem_rdata;
            pcd_n   = pcf_q;
            pcp4_n  = pcf_plus4;
            valid_n = 1'b1;
            pcf_n   = pcf_plus4;
          end
        end else if (!StallD) begin
          // Nothing arrived: hand decode a bubble with fixed PC fields.
          instr_n = NOP_INSTR;
          pcd_n   = 32'd0;
          pcp4_n  = 32'd0;
          valid_n = 1'b0;
        end
      end
      HOLD: begin
        if (BranchTakenE) begin
          pcf_n   = target;
          state_n = FETCH;
        end else if (!StallD) begin
          // The buffered word belongs to PCF, which only advances here.
          instr_n = skid_q;
          pcd_n   = pcf_q;
          pcp4_n  = pcf_plus4;
          valid_n = 1'b1;
          pcf_n   = pcf_plus4;
          state_n = FETCH;
        end
      end
      DRAIN: begin
        if (BranchTakenE) begin
          pcf_n = target;
        end
        if (imem_rvalid) begin
          state_n = FETCH;
        end
        if (!StallD) begin
          instr_n = NOP_INSTR;
          pcd_n   = 32'd0;
          pcp4_n  = 32'd0;
          valid_n = 1'b0;
        end
      end
      default: begin
        state_n = FETCH;
      end
    endcase

    // Flush wins over stall and over any load chosen above.
    if (kill_d) begin
      instr_n = NOP_INSTR;
      pcd_n   = 32'd0;
      pcp4_n  = 32'd0;
      valid_n = 1'b0;
    end
  end

  // State, PC, skid buffer and IF/ID register, with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= FETCH;
      pcf_q   <= RESET_PC;
      skid_q  <= 32'd0;
      instr_q <= NOP_INSTR;
      pcd_q   <= 32'd0;
      pcp4_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_n;
      pcf_q   <= pcf_n;
      skid_q  <= skid_n;
      instr_q <= instr_n;
      pcd_q   <= pcd_n;
      pcp4_q  <= pcp4_n;
      valid_q <= valid_n;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by random stimulus, with an
// instruction-memory responder and a behavioural model of the fetch stage.
module tb_if_stage;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_ni;
  logic        StallD, FlushD, BranchTakenE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic [24:0] ImmD;
  logic        ValidD;
  logic [1:0]  dbg_state;

  if_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .StallD(StallD), .FlushD(FlushD),
    .BranchTakenE(BranchTakenE), .PCTargetE(PCTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmD(ImmD),
    .ValidD(ValidD), .dbg_state(dbg_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: fetch PC, skid buffer, drain flag, expected IF/ID.
  logic [31:0] m_pc, m_buf;
  logic        m_buf_full, m_drain;
  logic [31:0] e_instr, e_pcd, e_pcp4;
  logic        e_valid;

  // Memory responder.
  logic        pend, last_rv;
  logic [31:0] paddr;
  int          cnt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_bubble();
    e_instr = NOP; e_pcd = 32'd0; e_pcp4 = 32'd0; e_valid = 1'b0;
  endtask

  // One clock: drive inputs, respond as memory, advance model, check outputs.
  task automatic step(input logic rst, input logic stall, input logic flush,
                      input logic br, input logic [31:0] tgt, input int lat);
    logic exp_req;
    logic [31:0] t;
    @(negedge clk);
    rst_ni = rst; StallD = stall; FlushD = flush; BranchTakenE = br; PCTargetE = tgt;
    #1;
    if (last_rv) pend = 1'b0;
    exp_req = rst && !m_buf_full && !m_drain;
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    if (!rst) begin
      pend = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    end else begin
      if (!pend && imem_req) begin pend = 1'b1; paddr = imem_addr; cnt = lat; end
      if (pend && cnt == 0) begin
        imem_rvalid = 1'b1; imem_rdata = mem_word(paddr);
      end else begin
        imem_rvalid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
        if (pend) cnt--;
      end
    end
    last_rv = imem_rvalid;
    // Model the rising edge.
    t = {tgt[31:2], 2'b00};
    if (!rst) begin
      m_pc = RST_PC; m_buf_full = 1'b0; m_drain = 1'b0; set_bubble();
    end else begin
      if (m_drain) begin
        if (br) m_pc = t;
        if (imem_rvalid) m_drain = 1'b0;
        if (!stall) set_bubble();
      end else if (m_buf_full) begin
        if (br) begin
          m_pc = t; m_buf_full = 1'b0;
        end else if (!stall) begin
          e_instr = m_buf; e_pcd = m_pc; e_pcp4 = m_pc + 32'd4; e_valid = 1'b1;
          m_pc = m_pc + 32'd4; m_buf_full = 1'b0;
        end
      end else begin
        if (br) begin
          m_pc = t; m_drain = !imem_rvalid;
        end else if (imem_rvalid) begin
          if (stall) begin
            m_buf = imem_rdata; m_buf_full = 1'b1;
          end else begin
            e_instr = imem_rdata; e_pcd = m_pc; e_pcp4 = m_pc + 32'd4; e_valid = 1'b1;
            m_pc = m_pc + 32'd4;
          end
        end else if (!stall) begin
          set_bubble();
        end
      end
      if (flush || br) set_bubble();
    end
    @(posedge clk);
    #1;
    chk("InstrD", InstrD, e_instr);
    chk("PCD", PCD, e_pcd);
    chk("PCPlus4D", PCPlus4D, e_pcp4);
    chk("ValidD", 32'(ValidD), 32'(e_valid));
    chk("ImmD", 32'(ImmD), 32'(e_instr[31:7]));
    chk("state_legal", 32'(dbg_state != 2'd3), 32'd1);
    if (ValidD) begin
      chk("fetched_word", InstrD, mem_word(PCD));
      chk("pc_plus4", PCPlus4D, PCD + 32'd4);
    end
  endtask

  // Directed scenarios, then random traffic, then the report.
  initial begin
    logic [31:0] nop_v;
    nop_v = NOP;
    rst_ni = 1'b0; StallD = 1'b0; FlushD = 1'b0; BranchTakenE = 1'b0;
    PCTargetE = 32'd0; imem_rvalid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    m_pc = RST_PC; m_buf = 32'd0; m_buf_full = 1'b0; m_drain = 1'b0;
    set_bubble();
    pend = 1'b0; last_rv = 1'b0; paddr = 32'd0; cnt = 0;

    // Reset.
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("rst_instr", InstrD, NOP);
    chk("rst_valid", 32'(ValidD), 32'd0);
    chk("rst_imm", 32'(ImmD), 32'(nop_v[31:7]));

    // Zero-wait memory, first instruction.
    step(1, 0, 0, 0, 0, 0);
    chk("first_instr", InstrD, 32'h0050_0093);
    chk("first_pcd", PCD, 32'd0);
    chk("first_pcp4", PCPlus4D, 32'd4);
    chk("first_imm", 32'(ImmD), 32'h000_A001);
    chk("first_valid", 32'(ValidD), 32'd1);
    step(1, 0, 0, 0, 0, 0);
    chk("second_pcd", PCD, 32'd4);

    // Stall for three cycles while the word at 8 arrives.
    step(1, 1, 0, 0, 0, 0);
    chk("stall_hold_pcd", PCD, 32'd4);
    step(1, 1, 0, 0, 0, 0);
    chk("hold_req", 32'(imem_req), 32'd0);
    step(1, 1, 0, 0, 0, 0);
    chk("hold_pcd", PCD, 32'd4);
    step(1, 0, 0, 0, 0, 0);
    chk("release_pcd", PCD, 32'd8);
    chk("release_instr", InstrD, mem_word(32'd8));
    step(1, 0, 0, 0, 0, 0);
    chk("after_release_pcd", PCD, 32'd12);

    // Two-cycle memory, redirect to 0x102 mid-wait.
    step(1, 0, 0, 0, 0, 2);
    step(1, 0, 0, 1, 32'h0000_0102, 0);
    chk("redirect_valid", 32'(ValidD), 32'd0);
    step(1, 0, 0, 0, 0, 0);
    chk("drain_valid", 32'(ValidD), 32'd0);
    chk("redirect_req", 32'(imem_req), 32'd1);
    chk("redirect_addr", imem_addr, 32'h0000_0100);
    step(1, 0, 0, 0, 0, 0);
    chk("target_pcd", PCD, 32'h0000_0100);

    // Flush together with stall.
    step(1, 1, 1, 0, 0, 0);
    chk("flush_instr", InstrD, 32'h0000_0013);
    chk("flush_valid", 32'(ValidD), 32'd0);
    step(1, 0, 0, 0, 0, 0);

    // Wrap at the top of the address space.
    step(1, 0, 0, 1, 32'hFFFF_FFFC, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("wrap_pcd", PCD, 32'hFFFF_FFFC);
    chk("wrap_pcp4", PCPlus4D, 32'd0);
    chk("wrap_addr", imem_addr, 32'd0);

    // Reset pulse while holding.
    step(1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("rst_hold_instr", InstrD, NOP);
    chk("rst_hold_pcd", PCD, 32'd0);
    chk("rst_hold_pcp4", PCPlus4D, 32'd0);
    chk("rst_hold_valid", 32'(ValidD), 32'd0);
    chk("rst_hold_req", 32'(imem_req), 32'd0);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_restart_pcd", PCD, RST_PC);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
           $urandom, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
